// File: rtl/iq_block_averager.sv
// Averages each I/Q word of every channel over 2^AVG_LOG2 frames and streams the
// averaged frame out over valid/ready; counts aborted and dropped blocks.
module iq_block_averager #(
  parameter int DW       = 31,
  parameter int N_CH     = 4,
  parameter int AVG_LOG2 = 4
) (
  input  logic          clk_adc,
  input  logic          reset,
  input  logic [DW-1:0] stream_in,
  input  logic          strobe_in,
  output logic [DW-1:0] out_data,
  output logic [3:0]    out_idx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    drop_cnt,
  output logic [7:0]    abort_cnt
);

  localparam int NW    = 2 * N_CH;
  localparam int ACC_W = DW + AVG_LOG2;
  localparam int WW    = (NW > 1) ? $clog2(NW) : 1;
  localparam int FW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t state, state_next;
  logic [3:0] idx_next;

  logic [WW-1:0] wcnt;
  logic [FW-1:0] fcnt;

  logic signed [ACC_W-1:0] acc [NW];
  logic signed [ACC_W-1:0] fin_sum [NW];
  logic        [DW-1:0]    avg [NW];
  logic        [DW-1:0]    obuf [NW];

  logic signed [ACC_W-1:0] word_ext;
  logic signed [ACC_W-1:0] acc_sum;

  logic last_word, last_frame, first_frame;
  logic frame_err, block_done, buf_free, load, drop;
  logic [WW-1:0] rd_sel;

  assign last_word   = (wcnt == WW'(NW - 1));
  assign last_frame  = (fcnt == FW'((1 << AVG_LOG2) - 1));
  assign first_frame = (fcnt == '0);

  assign frame_err  = !strobe_in && (wcnt != '0);
  assign block_done = strobe_in && last_word && last_frame;

  always_comb begin
    word_ext = ACC_W'($signed(stream_in));
    acc_sum  = first_frame ? word_ext : acc[wcnt] + word_ext;
  end

  // The last word of a block is still in flight, so its sum bypasses the accumulator.
  always_comb begin
    for (int k = 0; k < NW; k++) begin
      fin_sum[k] = (k == NW - 1) ? acc_sum : acc[k];
      avg[k]     = DW'(fin_sum[k] >>> AVG_LOG2);
    end
  end

  // The final handshake frees the buffer in the same cycle, so a block finishing then is kept.
  assign buf_free = (state == IDLE) ||
                    ((state == SEND) && out_ready && (out_idx == 4'(NW - 1)));
  assign load     = block_done && buf_free;
  assign drop     = block_done && !buf_free;

  always_ff @(posedge clk_adc) begin
    if (!reset) begin
      wcnt <= '0;
      fcnt <= '0;
      for (int k = 0; k < NW; k++) acc[k] <= '0;
    end else if (frame_err) begin
      wcnt <= '0;
      fcnt <= '0;
    end else if (strobe_in) begin
      acc[wcnt] <= acc_sum;
      if (last_word) begin
        wcnt <= '0;
        fcnt <= last_frame ? '0 : FW'(fcnt + 1'b1);
      end else begin
        wcnt <= WW'(wcnt + 1'b1);
      end
    end
  end

  always_ff @(posedge clk_adc) begin
    if (!reset) begin
      for (int k = 0; k < NW; k++) obuf[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < NW; k++) obuf[k] <= avg[k];
    end
  end

  always_ff @(posedge clk_adc) begin
    if (!reset) begin
      drop_cnt  <= '0;
      abort_cnt <= '0;
    end else begin
      if (drop && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
      if (frame_err && (abort_cnt != 8'hFF))
        abort_cnt <= abort_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_adc) begin
    if (!reset) begin
      state   <= IDLE;
      out_idx <= '0;
    end else begin
      state   <= state_next;
      out_idx <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = out_idx;
    case (state)
      IDLE: begin
        if (load) begin
          state_next = SEND;
          idx_next   = '0;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (out_idx == 4'(NW - 1)) begin
            idx_next   = '0;
            state_next = load ? SEND : IDLE;
          end else begin
            idx_next = out_idx + 4'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  assign rd_sel    = out_idx[WW-1:0];
  assign out_valid = (state == SEND);
  assign out_data  = out_valid ? obuf[rd_sel] : '0;

endmodule

// File: tb/tb_iq_block_averager.sv
// Directed bench for iq_block_averager (DW=31, N_CH=4, AVG_LOG2=4): constant,
// floor, framing error, backpressure, coincident load, reset and saturation.
module tb_iq_block_averager;

  logic        clk_adc = 1'b0;
  logic        reset;
  logic [30:0] stream_in;
  logic        strobe_in;
  logic [30:0] out_data;
  logic [3:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  drop_cnt;
  logic [7:0]  abort_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk_adc = ~clk_adc;

  iq_block_averager #(.DW(31), .N_CH(4), .AVG_LOG2(4)) dut (
    .clk_adc  (clk_adc),
    .reset    (reset),
    .stream_in(stream_in),
    .strobe_in(strobe_in),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .drop_cnt (drop_cnt),
    .abort_cnt(abort_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // mode 1: word k = 1000*(k+1); mode 0: every word = v
  task automatic send_frame(input int mode, input int v);
    for (int k = 0; k < 8; k++) begin
      strobe_in = 1'b1;
      stream_in = (mode != 0) ? 31'(1000 * (k + 1)) : 31'(v);
      @(negedge clk_adc);
    end
  endtask

  task automatic send_frames(input int mode, input int v, input int n);
    for (int f = 0; f < n; f++) send_frame(mode, v);
  endtask

  // Expects a block already presented at idx 0 and out_ready held high.
  task automatic read_block(input int mode, input int v);
    for (int k = 0; k < 8; k++) begin
      chk("rd_valid", 32'(out_valid), 32'd1);
      chk("rd_idx", 32'(out_idx), 32'(k));
      chk("rd_data", 32'($signed(out_data)), (mode != 0) ? 32'(1000 * (k + 1)) : 32'(v));
      @(negedge clk_adc);
    end
    chk("rd_done_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    strobe_in = 1'b0;
    stream_in = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk_adc);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_abort", 32'(abort_cnt), 32'd0);
    reset = 1'b1;
    @(negedge clk_adc);

    // Constant ramp per index: averages equal the per-index constant.
    send_frames(1, 0, 15);
    send_frame(1, 0);
    strobe_in = 1'b0;
    read_block(1, 0);

    // Alternating -1 / 0 frames: sum -8, floor(-0.5) = -1.
    for (int f = 0; f < 16; f++) send_frame(0, (f % 2 == 1) ? -1 : 0);
    strobe_in = 1'b0;
    read_block(0, -1);

    // Framing error after word 3 of frame 5, then a clean block of 7s.
    send_frames(0, 100, 5);
    for (int k = 0; k < 4; k++) begin
      strobe_in = 1'b1;
      stream_in = 31'd100;
      @(negedge clk_adc);
    end
    strobe_in = 1'b0;
    stream_in = 31'd999;
    @(negedge clk_adc);
    chk("abort_cnt", 32'(abort_cnt), 32'd1);
    chk("abort_no_out", 32'(out_valid), 32'd0);
    send_frames(0, 7, 16);
    strobe_in = 1'b0;
    read_block(0, 7);
    chk("abort_stable", 32'(abort_cnt), 32'd1);

    // Backpressure across two blocks: first held, second dropped.
    out_ready = 1'b0;
    send_frames(0, 3, 16);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_idx", 32'(out_idx), 32'd0);
    chk("bp_data", 32'($signed(out_data)), 32'd3);
    send_frames(0, 5, 16);
    strobe_in = 1'b0;
    chk("bp_drop", 32'(drop_cnt), 32'd1);
    chk("bp_hold_idx", 32'(out_idx), 32'd0);
    chk("bp_hold_data", 32'($signed(out_data)), 32'd3);
    out_ready = 1'b1;
    read_block(0, 3);

    // Final handshake coincides with the next block's completion.
    out_ready = 1'b0;
    send_frames(0, 11, 16);
    send_frames(0, 13, 15);
    chk("sim_hold_idx", 32'(out_idx), 32'd0);
    chk("sim_hold_data", 32'($signed(out_data)), 32'd11);
    out_ready = 1'b1;
    send_frame(0, 13);
    strobe_in = 1'b0;
    chk("sim_drop", 32'(drop_cnt), 32'd1);
    read_block(0, 13);

    // Reset mid-block clears counters and partial sums.
    send_frames(0, 50, 10);
    strobe_in = 1'b0;
    reset = 1'b0;
    @(negedge clk_adc);
    chk("mrst_drop", 32'(drop_cnt), 32'd0);
    chk("mrst_abort", 32'(abort_cnt), 32'd0);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_idx", 32'(out_idx), 32'd0);
    chk("mrst_data", 32'(out_data), 32'd0);
    reset = 1'b1;
    send_frames(0, 20, 16);
    strobe_in = 1'b0;
    read_block(0, 20);

    // 260 framing errors: abort_cnt saturates at 255.
    for (int n = 0; n < 260; n++) begin
      strobe_in = 1'b1;
      stream_in = 31'd1;
      @(negedge clk_adc);
      strobe_in = 1'b0;
      @(negedge clk_adc);
    end
    chk("abort_sat", 32'(abort_cnt), 32'd255);
    chk("sat_drop", 32'(drop_cnt), 32'd0);
    chk("sat_valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
